mdu_hilo: RTL
=============

// Module: mdu_hilo
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
//  Sits directly downstream of the register file: operands a/b come from ReadData1/ReadData2.
//  mfhi/mflo results return through hi/lo to the WriteData mux.
//  Radix-2 shift-add multiply and restoring divide; 32 iterations each; start/busy/done handshake.
// PARAMETERS
//  WIDTH   32   operand/HI/LO width; iteration count = WIDTH
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      request operation; sampled only in IDLE or DONE
//  op         in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//  a          in   WIDTH  multiplicand / dividend (rs)
//  b          in   WIDTH  multiplier / divisor (rt)
//  mthi       in   1      write wdata into HI
//  mtlo       in   1      write wdata into LO
//  wdata      in   WIDTH  mthi/mtlo data
//  busy       out  1      operation in progress
//  done       out  1      one-cycle pulse; hi/lo valid
//  div_by_zero out 1      held with done when a divide had b==0
//  hi         out  WIDTH  HI register (product high / remainder)
//  lo         out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-low.
//  - Reset (rst_n==0 at an edge): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
//    Reset mid-operation discards the operation; HI/LO are cleared.
//  - FSM states: IDLE, BUSY, DONE. DONE always lasts one cycle, then returns to IDLE.
//    A start seen in DONE is accepted exactly as in IDLE.
//  - Accept edge E0 (start=1 in IDLE/DONE): latch operands and op; clear counter; go to BUSY.
//    busy=1 from after E0 through the cycle before E32.
//  - Iterations: edges E1..E32, one iteration per edge.
//    At E32: write hi/lo; go to DONE. done=1 for the cycle after E32. Latency is 33 cycles, start to done.
//  - MULTU: {hi,lo} = a*b, full 2*WIDTH product.
//  - DIVU: lo = a/b, hi = a%b.
//  - Divide with b==0: detected at E0. Skip BUSY; go straight to DONE.
//    hi=a, lo={WIDTH{1'b1}}, div_by_zero=1 during that done cycle; done is high the cycle after E0.
//  - div_by_zero=0 on every other done.
//  - start while BUSY: ignored; no queueing.
//  - mthi/mtlo in IDLE/DONE: the addressed register takes wdata at the next edge; both may be written together.
//  - mthi/mtlo while BUSY: ignored.
//  - start together with mthi/mtlo: start wins; the write is dropped.
//  - mthi/mtlo in DONE: the write overrides the just-produced result for that register.
//  - hi/lo hold their value between operations; they change only at E32, on a div0 accept, on mthi/mtlo, or on reset.
// CONFIGURATION
//  MDU_SIGNED_EN defined:
//   - op[1]=1 selects signed ops. Operands are converted to magnitudes.
//   - MULT: product negated if signs differ.
//   - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
//   - Special case 0x80000000 / -1: lo=0x80000000, hi=0.
//  MDU_SIGNED_EN undefined:
//   - op[1] ignored; MULT/DIV execute as MULTU/DIVU.
//   - No sign logic is synthesised.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
//  2. DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002, div_by_zero=0.
//  3. MDU_SIGNED_EN: MULT -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
//     Then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     Macro off: same MULT stimulus -> hi=0x00000003, lo=0xFFFFFFF4.
//  4. DIVU a=0x12345678 b=0 -> done the cycle after accept; div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF.
//  5. MULTU 6*7 in flight; at busy cycle 10 pulse start (a=1,b=1) and mtlo wdata=0xDEAD
//     -> both ignored; final hi=0, lo=0x2A.
//     Then mthi 0xBEEF in IDLE -> hi=0xBEEF next edge.
//  6. DIVU 1000/3 started; rst_n=0 at busy cycle 15 -> after that edge busy=0, done=0, hi=lo=0.
//     A new MULTU 2*3 then yields lo=6.

Source files
------------

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Define MDU_SIGNED_EN to add signed MULT/DIV; otherwise op[1] is ignored.
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shf;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_n;
    logic [WIDTH-1:0] w_q_n;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

`ifdef MDU_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_neg = op[1] & a[WIDTH-1];
    assign w_b_neg = op[1] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
`else
    logic w_unused_op1;

    assign w_unused_op1 = op[1];
    assign w_a_mag      = a;
    assign w_b_mag      = b;
`endif

    // r_q holds the multiplier / dividend bits; r_acc the partial product / remainder
    assign w_add = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_shf = {r_acc, r_q[WIDTH-1]};
    assign w_ge  = w_shf >= {1'b0, r_b};
    assign w_sub = w_shf[WIDTH-1:0] - r_b;

    always_comb begin
        w_acc_n = '0;
        w_q_n   = '0;
        if (r_div) begin
            w_acc_n = w_ge ? w_sub : w_shf[WIDTH-1:0];
            w_q_n   = {r_q[WIDTH-2:0], w_ge};
        end else begin
            w_acc_n = w_add[WIDTH:1];
            w_q_n   = {w_add[0], r_q[WIDTH-1:1]};
        end
    end

`ifdef MDU_SIGNED_EN
    always_comb begin
        w_prod   = {w_acc_n, w_q_n};
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_div) begin
            w_res_lo = r_neg_q ? -w_q_n : w_q_n;
            w_res_hi = r_neg_r ? -w_acc_n : w_acc_n;
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end
            {w_res_hi, w_res_lo} = w_prod;
        end
    end
`else
    assign w_res_hi = w_acc_n;
    assign w_res_lo = w_q_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
`ifdef MDU_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_div <= op[0];
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_q   <= w_a_mag;
                        r_b   <= w_b_mag;
`ifdef MDU_SIGNED_EN
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
`endif
                        if (op[0] && (b == '0)) begin
                            r_hi    <= a;
                            r_lo    <= '1;
                            r_done  <= 1'b1;
                            r_dz    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_BUSY;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        if (mthi) begin
                            r_hi <= wdata;
                        end
                        if (mtlo) begin
                            r_lo <= wdata;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
